// File: rtl/clk_rst_pkg.sv
// Shared constants for the clock/reset power-up sequencer: state encodings,
// widths and the state-to-output decode used by the registered output stage.
package clk_rst_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 16;
    localparam int RETRY_W = 2;

    localparam logic [STATE_W-1:0] S_PWR     = 3'd0;
    localparam logic [STATE_W-1:0] S_LOCK    = 3'd1;
    localparam logic [STATE_W-1:0] S_MCB_RST = 3'd2;
    localparam logic [STATE_W-1:0] S_CALIB   = 3'd3;
    localparam logic [STATE_W-1:0] S_REL     = 3'd4;
    localparam logic [STATE_W-1:0] S_RUN     = 3'd5;
    localparam logic [STATE_W-1:0] S_RETRY   = 3'd6;
    localparam logic [STATE_W-1:0] S_FAULT   = 3'd7;

    typedef struct packed {
        logic pll_rst;
        logic mcb_rst;
        logic fb_rst_req;
        logic pix_rst_req;
        logic init_done;
        logic fault;
    } seq_out_t;

    // Everything held in reset unless the state explicitly lets it go.
    function automatic seq_out_t decode_outputs(input logic [STATE_W-1:0] s);
        seq_out_t o;
        o = '{pll_rst: 1'b1, mcb_rst: 1'b1, fb_rst_req: 1'b1, pix_rst_req: 1'b1,
              init_done: 1'b0, fault: 1'b0};
        case (s)
            S_LOCK, S_MCB_RST: o.pll_rst = 1'b0;
            S_CALIB: begin
                o.pll_rst = 1'b0;
                o.mcb_rst = 1'b0;
            end
            S_REL: begin
                o.pll_rst    = 1'b0;
                o.mcb_rst    = 1'b0;
                o.fb_rst_req = 1'b0;
            end
            S_RUN: begin
                o.pll_rst     = 1'b0;
                o.mcb_rst     = 1'b0;
                o.fb_rst_req  = 1'b0;
                o.pix_rst_req = 1'b0;
                o.init_done   = 1'b1;
            end
            S_FAULT: o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, asynchronously cleared to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_sequencer.sv
// Power-up / recovery sequencer: PLL/DCM reset, lock wait, MCB reset and
// calibration, then staggered release of frame-buffer and pixel resets.
module clk_rst_sequencer
    import clk_rst_pkg::*;
#(
    parameter int unsigned PWR_WAIT_CYC  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 40000,
    parameter int unsigned MCB_RST_CYC   = 8,
    parameter int unsigned CALIB_TIMEOUT = 60000,
    parameter int unsigned STAGGER_CYC   = 4,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic               clk_osc,
    input  logic               reset_n,
    input  logic               i_pll_lock,
    input  logic               i_dcm_locked,
    input  logic               i_bufpll_mcb_lock,
    input  logic               i_calib_done,
    input  logic               i_restart,
    output logic               o_pll_rst,
    output logic               o_mcb_rst,
    output logic               o_frame_buf_rst_req,
    output logic               o_pix_rst_req,
    output logic               o_init_done,
    output logic               o_fault,
    output logic [STATE_W-1:0] o_state,
    output logic [RETRY_W-1:0] o_retry_cnt
);

    localparam logic [CNT_W-1:0]   PWR_LAST   = CNT_W'(PWR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   MCB_LAST   = CNT_W'(MCB_RST_CYC - 1);
    localparam logic [CNT_W-1:0]   CALIB_LAST = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STAG_LAST  = CNT_W'(STAGGER_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

    logic [STATE_W-1:0] state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry_cnt;
    seq_out_t           outs_q;

    logic [3:0] sync_d, sync_q;
    logic       pll_lock_s, dcm_locked_s, bufpll_mcb_lock_s, calib_done_s, lock_all_s;

    // Status is masked while its source is held in reset, so a stale lock or
    // calibration from a previous attempt is flushed before it can be trusted.
    assign sync_d = {i_pll_lock        & ~outs_q.pll_rst,
                     i_dcm_locked      & ~outs_q.pll_rst,
                     i_bufpll_mcb_lock & ~outs_q.pll_rst,
                     i_calib_done      & ~outs_q.mcb_rst};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        sync_2ff u_sync (
            .clk   (clk_osc),
            .rst_n (reset_n),
            .d     (sync_d[i]),
            .q     (sync_q[i])
        );
    end

    assign {pll_lock_s, dcm_locked_s, bufpll_mcb_lock_s, calib_done_s} = sync_q;
    assign lock_all_s = pll_lock_s & dcm_locked_s & bufpll_mcb_lock_s;

    always_comb begin
        state_nxt = state;
        if (i_restart) begin
            state_nxt = S_PWR;
        end else begin
            case (state)
                S_PWR:     if (cnt == PWR_LAST) state_nxt = S_LOCK;
                S_LOCK: begin
                    if (lock_all_s)              state_nxt = S_MCB_RST;
                    else if (cnt == LOCK_LAST)   state_nxt = S_RETRY;
                end
                S_MCB_RST: begin
                    if (!lock_all_s)             state_nxt = S_RETRY;
                    else if (cnt == MCB_LAST)    state_nxt = S_CALIB;
                end
                S_CALIB: begin
                    if (!lock_all_s)             state_nxt = S_RETRY;
                    else if (calib_done_s)       state_nxt = S_REL;
                    else if (cnt == CALIB_LAST)  state_nxt = S_RETRY;
                end
                S_REL: begin
                    if (!lock_all_s || !calib_done_s) state_nxt = S_RETRY;
                    else if (cnt == STAG_LAST)        state_nxt = S_RUN;
                end
                S_RUN:     if (!lock_all_s || !calib_done_s) state_nxt = S_RETRY;
                // retry_cnt already holds the incremented value here.
                S_RETRY:   state_nxt = (retry_cnt >= RETRY_LIM) ? S_FAULT : S_PWR;
                S_FAULT:   state_nxt = S_FAULT;
                default:   state_nxt = S_PWR;
            endcase
        end
    end

    always_ff @(posedge clk_osc or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_PWR;
            cnt       <= '0;
            retry_cnt <= '0;
            outs_q    <= decode_outputs(S_PWR);
        end else begin
            state  <= state_nxt;
            cnt    <= (state_nxt != state || i_restart) ? '0 : cnt + CNT_W'(1);
            outs_q <= decode_outputs(state_nxt);
            if (i_restart)
                retry_cnt <= '0;
            else if (state_nxt == S_RETRY && retry_cnt != '1)
                retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end

    assign o_pll_rst           = outs_q.pll_rst;
    assign o_mcb_rst           = outs_q.mcb_rst;
    assign o_frame_buf_rst_req = outs_q.fb_rst_req;
    assign o_pix_rst_req       = outs_q.pix_rst_req;
    assign o_init_done         = outs_q.init_done;
    assign o_fault             = outs_q.fault;
    assign o_state             = state;
    assign o_retry_cnt         = retry_cnt;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Scoreboard bench: a timeline model predicts each state transition (state,
// cycle, retry count); a monitor pops and compares on every o_state change.
`timescale 1ns/1ps
module tb_clk_rst_sequencer;

    localparam int PWR = 16, LTO = 100, MCB = 8, CTO = 3, STG = 4, MAXR = 3;
    localparam int SYNC_LAT = 3;
    localparam logic [2:0] ST_PWR = 3'd0, ST_LOCK = 3'd1, ST_MCB = 3'd2, ST_CALIB = 3'd3,
                           ST_REL = 3'd4, ST_RUN = 3'd5, ST_RETRY = 3'd6, ST_FAULT = 3'd7;

    logic clk_osc = 1'b0, reset_n = 1'b0;
    logic pll = 1'b1, dcm = 1'b1, bufpll = 1'b1, cal = 1'b1, restart = 1'b0;
    logic o_pll_rst, o_mcb_rst, o_fb, o_pix, o_init_done, o_fault;
    logic [2:0] o_state;
    logic [1:0] o_retry_cnt;
    logic [5:0] outs;

    typedef struct { logic [2:0] st; int t; logic [1:0] rc; } ev_t;
    ev_t q[$];
    int  rc_m = 0;
    int  cyc = 0;
    int  errors = 0, checks = 0;
    logic [2:0] last_st = 3'd0;

    clk_rst_sequencer #(
        .PWR_WAIT_CYC(PWR), .LOCK_TIMEOUT(LTO), .MCB_RST_CYC(MCB),
        .CALIB_TIMEOUT(CTO), .STAGGER_CYC(STG), .MAX_RETRY(MAXR)
    ) dut (
        .clk_osc(clk_osc), .reset_n(reset_n),
        .i_pll_lock(pll), .i_dcm_locked(dcm), .i_bufpll_mcb_lock(bufpll),
        .i_calib_done(cal), .i_restart(restart),
        .o_pll_rst(o_pll_rst), .o_mcb_rst(o_mcb_rst),
        .o_frame_buf_rst_req(o_fb), .o_pix_rst_req(o_pix),
        .o_init_done(o_init_done), .o_fault(o_fault),
        .o_state(o_state), .o_retry_cnt(o_retry_cnt)
    );

    assign outs = {o_pll_rst, o_mcb_rst, o_fb, o_pix, o_init_done, o_fault};

    always #5 clk_osc = ~clk_osc;

    always @(posedge clk_osc) begin
        if (!reset_n) cyc = 0;
        else          cyc = cyc + 1;
    end

    // {pll_rst, mcb_rst, fb_req, pix_req, init_done, fault} required in each state
    function automatic logic [5:0] exp_out(input logic [2:0] st);
        case (st)
            ST_LOCK, ST_MCB: return 6'b011100;
            ST_CALIB:        return 6'b001100;
            ST_REL:          return 6'b000100;
            ST_RUN:          return 6'b000010;
            ST_FAULT:        return 6'b111101;
            default:         return 6'b111100;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- timeline model ----------------
    task automatic expect_ev(input logic [2:0] st, input int t);
        ev_t e;
        if (st == ST_RETRY && rc_m < 3) rc_m++;
        e.st = st; e.t = t; e.rc = 2'(rc_m);
        q.push_back(e);
    endtask

    // From a PWR entry at t0 with all locks present: returns the CALIB entry time.
    task automatic plan_to_calib(input int t0, output int t_cal);
        int t_lock;
        t_lock = t0 + PWR;
        expect_ev(ST_LOCK, t_lock);
        expect_ev(ST_MCB, t_lock + SYNC_LAT);
        t_cal = t_lock + SYNC_LAT + MCB;
        expect_ev(ST_CALIB, t_cal);
    endtask

    // calib_done is seen SYNC_LAT after CALIB entry; it wins a tie with the timeout.
    task automatic plan_release(input int t_cal, output int t_run);
        expect_ev(ST_REL, t_cal + SYNC_LAT);
        t_run = t_cal + SYNC_LAT + STG;
        expect_ev(ST_RUN, t_run);
    endtask

    task automatic plan_retry(input int t_retry, output int t_next);
        expect_ev(ST_RETRY, t_retry);
        t_next = t_retry + 1;
        expect_ev((rc_m >= MAXR) ? ST_FAULT : ST_PWR, t_next);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_osc) begin
        ev_t e;
        if (!reset_n) begin
            last_st = o_state;
        end else begin
            if (o_state !== last_st) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_transition: state %0d at cycle %0d, none predicted", o_state, cyc);
                end else begin
                    e = q.pop_front();
                    if (o_state !== e.st || cyc != e.t || o_retry_cnt !== e.rc) begin
                        errors++;
                        $display("FAIL transition: got state %0d cycle %0d retry %0d, expected state %0d cycle %0d retry %0d",
                                 o_state, cyc, o_retry_cnt, e.st, e.t, e.rc);
                    end
                end
                last_st = o_state;
            end
            check("outputs_vs_state", 32'(outs), 32'(exp_out(o_state)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_edge();
        @(posedge clk_osc); #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) next_edge();
    endtask

    task automatic release_reset();
        @(posedge clk_osc); #2;
        reset_n = 1'b1;
    endtask

    task automatic pulse_lock_loss(input int which);
        case (which)
            0:       pll = 1'b0;
            1:       dcm = 1'b0;
            default: bufpll = 1'b0;
        endcase
        next_edge();
        pll = 1'b1; dcm = 1'b1; bufpll = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t, tc, k;

        repeat (3) @(posedge clk_osc);
        #1;
        check("reset_state", 32'(o_state), 32'(ST_PWR));
        check("reset_retry", 32'(o_retry_cnt), 0);
        check("reset_outputs", 32'(outs), 32'(6'b111100));

        // Nominal power-up (also the calib/timeout tie, since CTO == SYNC_LAT)
        release_reset();
        rc_m = 0;
        plan_to_calib(0, tc);
        plan_release(tc, t);
        goto(t + 1);

        // Run-time loss of one lock input for a single cycle
        goto(t + $urandom_range(2, 20));
        k = cyc;
        pulse_lock_loss($urandom_range(0, 2));
        plan_retry(k + SYNC_LAT, t);
        plan_to_calib(t, tc);
        plan_release(tc, t);
        goto(t + 1);

        // Second loss, then restart while in CALIB
        goto(t + $urandom_range(2, 20));
        k = cyc;
        pulse_lock_loss($urandom_range(0, 2));
        plan_retry(k + SYNC_LAT, t);
        plan_to_calib(t, tc);
        goto(tc + $urandom_range(0, 1));
        k = cyc;
        restart = 1'b1;
        next_edge();
        restart = 1'b0;
        rc_m = 0;
        expect_ev(ST_PWR, k + 1);
        plan_to_calib(k + 1, tc);
        plan_release(tc, t);
        goto(t + 1);

        // Calibration lost in RUN, then a calibration timeout, then recovery
        goto(t + $urandom_range(2, 20));
        k = cyc;
        cal = 1'b0;
        plan_retry(k + SYNC_LAT, t);
        plan_to_calib(t, tc);
        plan_retry(tc + CTO, t);
        goto(tc + CTO);
        cal = 1'b1;
        plan_to_calib(t, tc);
        plan_release(tc, t);

        // Asynchronous reset while in REL
        goto(t - STG + $urandom_range(0, STG - 1));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", 32'(o_state), 32'(ST_PWR));
        check("async_rst_retry", 32'(o_retry_cnt), 0);
        check("async_rst_outputs", 32'(outs), 32'(6'b111100));
        q.delete();
        rc_m = 0;
        repeat (2) next_edge();

        // PLL never locks: three timed-out attempts end in FAULT
        pll = 1'b0;
        release_reset();
        t = 0;
        for (int a = 0; a < MAXR; a++) begin
            expect_ev(ST_LOCK, t + PWR);
            plan_retry(t + PWR + LTO, t);
        end
        goto(t + $urandom_range(5, 15));

        // Restart out of FAULT with the PLL now healthy
        k = cyc;
        restart = 1'b1;
        pll = 1'b1;
        next_edge();
        restart = 1'b0;
        rc_m = 0;
        expect_ev(ST_PWR, k + 1);
        plan_to_calib(k + 1, tc);
        plan_release(tc, t);
        goto(t + 5);

        check("scoreboard_drained", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
